uart_rx: RTL
============

# uart_rx

UART receiver for the uart_protocol design: recovers DWIDTH-bit frames from the serial line using PRESCALE-times oversampling on the receive clock. It is the counterpart of the existing transmitter, which runs at the baud clock (TXPERIOD = RXPERIOD × PRESCALE). Frames are start bit, DWIDTH data bits LSB first, optional parity, and one stop bit. Each frame is delivered as a one-cycle `data_valid` strobe with per-frame parity and stop error flags.

## Interface
- DWIDTH, 8, data bits per frame (from param_pkg)
- PWIDTH, 6, width of the prescale input (from param_pkg)
- CLK  input  1  receive clock (period RXPERIOD)
- RST  input  1  asynchronous, active-low reset
- RX_IN  input  1  serial line, idle high, asynchronous to CLK
- Prescale  input  PWIDTH  oversampling ratio; legal values are even, 8..32
- PAR_EN  input  1  1 = parity bit present
- PAR_TYP  input  1  0 = even, 1 = odd
- P_DATA  output  DWIDTH  received data; holds until the next valid frame
- data_valid  output  1  one-cycle strobe; frame good
- par_err  output  1  one-cycle strobe; parity mismatch
- stp_err  output  1  one-cycle strobe; stop bit sampled 0

## Operation
- RX_IN passes through a 2-flop synchronizer; all logic uses the synchronized value `rx_s`.
- State machine states: IDLE, START, DATA, PARITY, STOP.
- IDLE: when `rx_s` = 0, latch Prescale, PAR_EN and PAR_TYP, set edge_cnt = 0, and go to START. This detect cycle is T0. Configuration changes mid-frame are ignored.
- edge_cnt counts 0..P-1 within each bit (P = latched prescale) and wraps to 0. bit_cnt advances on the wrap.
- Sampling: take `rx_s` at edge_cnt P/2-1, P/2 and P/2+1. The bit value is the 2-of-3 majority, decided at P/2+1.
- START: if the majority is 1 (glitch), go to IDLE with no flags. Otherwise go to DATA at the bit end.
- DATA: shift samples into a holding register LSB first. After DWIDTH bits go to PARITY if PAR_EN=1, else STOP.
- PARITY: the expected bit is XOR of the data for PAR_TYP=0, or its inverse for PAR_TYP=1. A mismatch is recorded.
- STOP: leave the state in the cycle after the stop decision, going to IDLE without waiting for the bit end, so back-to-back frames are caught.
  - Good frame (stop = 1, no parity mismatch): pulse data_valid and load P_DATA.
  - Bad frame: pulse par_err and/or stp_err; P_DATA is unchanged and data_valid stays 0.
- Line held low (break): each frame time yields stp_err and the receiver re-arms. No lockup.

## Timing
- Reset values: P_DATA = 0, data_valid = 0, par_err = 0, stp_err = 0, state IDLE, both synchronizer flops = 1.
- Bit k spans T0 + k·P .. T0 + k·P + P-1. The start bit is k = 0.
- Strobes fire in cycle T0 + S·P + P/2 + 2, where S = DWIDTH+1 (no parity) or DWIDTH+2 (parity).
- Latency with P = 8 and T0 = RX_IN fall + 2:
  - no parity: 80 CLK from RX_IN fall to data_valid
  - parity: 88 CLK
- Strobes are high for exactly 1 cycle. par_err and stp_err may assert in the same cycle.
- Asynchronous reset mid-frame aborts the frame: no strobe, and outputs return to reset values.

## Structure
- param_pkg gains `rx_state_e`, the enum of the 5 states. DWIDTH, PWIDTH and PRESCALE are reused from it.
- One sub-module: `uart_rx_sampler`, containing the synchronizer, edge counter and 3-sample majority. It outputs `sample_done` and `sampled_bit`.

## Test plan
- Prescale=8, PAR_EN=0, send 0xA5 → data_valid at 80 CLK after the start edge, P_DATA=0xA5, no errors.
- Prescale=8, PAR_EN=1, PAR_TYP=0, send 0x3C with parity 0 → data_valid at 88 CLK. Repeat with parity 1 → par_err only, P_DATA keeps 0x3C.
- Prescale=16, PAR_TYP=1, back-to-back frames 0x01, 0xFF with no idle gap → two data_valid strobes, values correct.
- Start glitch: RX_IN low for 3 CLK → no strobes, state back in IDLE. A following valid 0x5A is received correctly.
- Stop bit forced 0 on frame 0x77 → stp_err=1, data_valid=0. RST asserted at bit 4 of the next frame → all outputs 0 and no strobes after release.
- Single-cycle noise pulse at the sample point P/2 of data bit 2 → majority rejects it, data correct.

Source files
------------

// File: rtl/param_pkg.sv
// Shared parameters and types for the uart_protocol design.
// Holds the frame width, the prescale port width and the receiver state enum.
package param_pkg;

    localparam int DWIDTH   = 8;
    localparam int PWIDTH   = 6;
    localparam int PRESCALE = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Serial-line front end: 2-flop synchronizer, per-bit edge counter and
// 3-sample majority vote around the bit centre.
module uart_rx_sampler
    import param_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_rx,
    input  logic              i_start,
    input  logic              i_active,
    input  logic [PWIDTH-1:0] i_prescale,
    output logic              o_rx_s,
    output logic              o_sample_done,
    output logic              o_sampled_bit
);

    logic              r_sync1;
    logic              r_sync2;
    logic              r_samp0;
    logic              r_samp1;
    logic [PWIDTH-1:0] r_edge_cnt;
    logic [PWIDTH-1:0] w_half;
    logic [PWIDTH-1:0] w_last;

    assign w_half = {1'b0, i_prescale[PWIDTH-1:1]};
    assign w_last = i_prescale - 1'b1;
    assign o_rx_s = r_sync2;

    // The detect cycle itself is count 0, so the counter is seeded with 1.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1       <= 1'b1;
            r_sync2       <= 1'b1;
            r_samp0       <= 1'b1;
            r_samp1       <= 1'b1;
            r_edge_cnt    <= '0;
            o_sample_done <= 1'b0;
            o_sampled_bit <= 1'b1;
        end else begin
            r_sync1       <= i_rx;
            r_sync2       <= r_sync1;
            o_sample_done <= 1'b0;
            if (i_start) begin
                r_edge_cnt <= PWIDTH'(1);
            end else if (i_active) begin
                r_edge_cnt <= (r_edge_cnt == w_last) ? '0 : r_edge_cnt + 1'b1;
                if (r_edge_cnt == w_half - 1'b1)
                    r_samp0 <= r_sync2;
                if (r_edge_cnt == w_half)
                    r_samp1 <= r_sync2;
                if (r_edge_cnt == w_half + 1'b1) begin
                    o_sample_done <= 1'b1;
                    o_sampled_bit <= majority3(r_samp0, r_samp1, r_sync2);
                end
            end else begin
                r_edge_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/parity/stop recovery with one-cycle
// data_valid, par_err and stp_err strobes.
module uart_rx
    import param_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              RX_IN,
    input  logic [PWIDTH-1:0] Prescale,
    input  logic              PAR_EN,
    input  logic              PAR_TYP,
    output logic [DWIDTH-1:0] P_DATA,
    output logic              data_valid,
    output logic              par_err,
    output logic              stp_err
);

    localparam int                BCW      = $clog2(DWIDTH);
    localparam logic [BCW-1:0]    BIT_LAST = BCW'(DWIDTH - 1);

    rx_state_e         r_state;
    logic [PWIDTH-1:0] r_prescale;
    logic              r_par_en;
    logic              r_par_typ;
    logic              r_par_bad;
    logic [DWIDTH-1:0] r_shift;
    logic [BCW-1:0]    r_bit_cnt;

    logic w_rx_s;
    logic w_start;
    logic w_active;
    logic w_sample_done;
    logic w_sampled_bit;

    assign w_start  = (r_state == IDLE) && !w_rx_s;
    assign w_active = (r_state != IDLE);

    uart_rx_sampler u_sampler (
        .i_clk         (CLK),
        .i_rst_n       (RST),
        .i_rx          (RX_IN),
        .i_start       (w_start),
        .i_active      (w_active),
        .i_prescale    (r_prescale),
        .o_rx_s        (w_rx_s),
        .o_sample_done (w_sample_done),
        .o_sampled_bit (w_sampled_bit)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= IDLE;
            r_prescale <= PWIDTH'(PRESCALE);
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_par_bad  <= 1'b0;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            P_DATA     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_prescale <= Prescale;
                        r_par_en   <= PAR_EN;
                        r_par_typ  <= PAR_TYP;
                        r_par_bad  <= 1'b0;
                        r_bit_cnt  <= '0;
                        r_state    <= START;
                    end
                end
                START: begin
                    if (w_sample_done)
                        r_state <= w_sampled_bit ? IDLE : DATA;
                end
                DATA: begin
                    if (w_sample_done) begin
                        r_shift   <= {w_sampled_bit, r_shift[DWIDTH-1:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == BIT_LAST)
                            r_state <= r_par_en ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (w_sample_done) begin
                        r_par_bad <= (w_sampled_bit != ((^r_shift) ^ r_par_typ));
                        r_state   <= STOP;
                    end
                end
                STOP: begin
                    // Return to IDLE right after the stop decision so a
                    // back-to-back start bit is not missed.
                    if (w_sample_done) begin
                        if (w_sampled_bit && !r_par_bad) begin
                            data_valid <= 1'b1;
                            P_DATA     <= r_shift;
                        end else begin
                            par_err <= r_par_bad;
                            stp_err <= !w_sampled_bit;
                        end
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
